cm_responder: RTL and testbench

//  MCU-side end of the CM bus guessing protocol, in hardware. Paces the link by generating cm_clk,

---
 rtl/cm_responder_if.sv | 22 ++
 rtl/cm_responder.sv | 184 ++++++++++++++++++
 tb/tb_cm_responder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cm_responder_if.sv
// CM bus between the MCU-side responder (master: paces cm_clk) and the guesser (slave).
// cm_in carries the resolved bus value seen by the responder.
interface cm_responder_if;
  logic [7:0] cm_in;
  logic [7:0] cm_out;
  logic       cm_oe;
  logic       cm_clk;

  modport master (
    input  cm_in,
    output cm_out,
    output cm_oe,
    output cm_clk
  );

  modport slave (
    output cm_in,
    input  cm_out,
    input  cm_oe,
    input  cm_clk
  );
endinterface

// File: rtl/cm_responder.sv
// CM bus responder: paces the link with cm_clk, receives START/guess/END frames and answers
// YES/NO after a delay that grows with the matching MSB-prefix length of the guess.
module cm_responder #(
  parameter int unsigned HALF_PER   = 8,
  parameter int unsigned BASE_DLY   = 4,
  parameter int unsigned LEAK_DLY   = 2,
  parameter int unsigned REPLY_HOLD = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK_50,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [7:0]       secret,
  cm_responder_if.master   bus,
  output logic             busy,
  output logic             found,
  output logic [7:0]       guess_q,
  output logic [CNT_W-1:0] attempt_count,
  output logic [7:0]       err_count,
  output logic             frame_err
);

  localparam logic [7:0]  CmStart   = 8'h01;
  localparam logic [7:0]  CmBegin   = 8'h02;
  localparam logic [7:0]  CmYes     = 8'h03;
  localparam logic [7:0]  CmNo      = 8'h04;
  localparam logic [7:0]  CmEnd     = 8'h05;
  localparam logic [15:0] HighLast  = 16'(HALF_PER - 1);
  localparam logic [15:0] PulseLast = 16'(2 * HALF_PER - 1);
  localparam logic [15:0] HoldLast  = 16'(REPLY_HOLD - 1);
  localparam logic [15:0] HalfPer   = 16'(HALF_PER);
  localparam logic [CNT_W-1:0] AttOne = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    StIdle, StBegin, StRel, StPace, StRxStart, StRxData, StRxEnd, StDelay, StReply
  } state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [7:0]  secret_q;
  logic        ferr_q;
  logic        yes_q;
  logic [7:0]  cm_out_q;
  logic        cm_oe_q;
  logic        cm_clk_q;

  logic [3:0]  lead;
  logic        lead_stop;
  logic [15:0] dly;
  logic        yes;
  logic        pulse_state;
  logic        pulse_done;
  logic        sample_now;
  logic [15:0] cnt_inc;

  assign bus.cm_out = cm_out_q;
  assign bus.cm_oe  = cm_oe_q;
  assign bus.cm_clk = cm_clk_q;

  // Leading matching bits, MSB first; the delay grows linearly with it.
  always_comb begin
    lead      = 4'd0;
    lead_stop = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (lead_stop || (guess_q[i] != secret_q[i])) lead_stop = 1'b1;
      else                                          lead      = lead + 4'd1;
    end
    dly = 16'(BASE_DLY) + 16'(LEAK_DLY) * {12'd0, lead};
    yes = (lead == 4'd8) && !ferr_q;
  end

  always_comb begin
    pulse_state = (state_q == StPace) || (state_q == StRxStart) ||
                  (state_q == StRxData) || (state_q == StRxEnd);
    cnt_inc     = cnt_q + 16'd1;
    pulse_done  = (cnt_q == PulseLast);
    sample_now  = (cnt_q == HighLast);
  end

  always_ff @(posedge CLK_50) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      secret_q      <= '0;
      ferr_q        <= 1'b0;
      yes_q         <= 1'b0;
      cm_out_q      <= '0;
      cm_oe_q       <= 1'b0;
      cm_clk_q      <= 1'b0;
      busy          <= 1'b0;
      found         <= 1'b0;
      guess_q       <= '0;
      attempt_count <= '0;
      err_count     <= '0;
      frame_err     <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      // Shared pulse sequencing; consecutive pulses chain except after the END slot.
      if (pulse_state) begin
        cnt_q    <= pulse_done ? 16'd0 : cnt_inc;
        cm_clk_q <= pulse_done ? (state_q != StRxEnd) : (cnt_inc < HalfPer);
      end
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            secret_q      <= secret;
            found         <= 1'b0;
            attempt_count <= '0;
            err_count     <= '0;
            busy          <= 1'b1;
            cm_oe_q       <= 1'b1;
            cm_out_q      <= CmBegin;
            cnt_q         <= '0;
            state_q       <= StBegin;
          end
        end
        StBegin: begin
          if (cnt_q == HoldLast) begin
            cm_oe_q  <= 1'b0;
            cm_out_q <= '0;
            state_q  <= StRel;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StRel: begin
          cnt_q    <= '0;
          cm_clk_q <= 1'b1;
          state_q  <= StPace;
        end
        StPace: begin
          if (pulse_done) state_q <= StRxStart;
        end
        StRxStart: begin
          if (sample_now && (bus.cm_in != CmStart)) ferr_q <= 1'b1;
          if (pulse_done) state_q <= StRxData;
        end
        StRxData: begin
          if (sample_now) guess_q <= bus.cm_in;
          if (pulse_done) state_q <= StRxEnd;
        end
        StRxEnd: begin
          if (sample_now && (bus.cm_in != CmEnd)) ferr_q <= 1'b1;
          if (pulse_done) state_q <= StDelay;
        end
        StDelay: begin
          if (cnt_inc >= dly) begin
            cnt_q    <= '0;
            cm_oe_q  <= 1'b1;
            cm_out_q <= yes ? CmYes : CmNo;
            yes_q    <= yes;
            if (attempt_count != {CNT_W{1'b1}}) attempt_count <= attempt_count + AttOne;
            if (ferr_q) begin
              frame_err <= 1'b1;
              ferr_q    <= 1'b0;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
            state_q <= StReply;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StReply: begin
          if (cnt_q == HoldLast) begin
            cnt_q    <= '0;
            cm_oe_q  <= 1'b0;
            cm_out_q <= '0;
            if (yes_q) begin
              found   <= 1'b1;
              busy    <= 1'b0;
              state_q <= StIdle;
            end else begin
              state_q <= StRel;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cm_responder.sv
// Bench for cm_responder: a guesser-side bus model drives frames and a reference model predicts
// replies, reply latency, counters and flags.
module tb_cm_responder;
  localparam int H  = 8;
  localparam int BD = 4;
  localparam int LD = 2;
  localparam int RH = 4;
  localparam int CW = 4;
  localparam int AttMax = (1 << CW) - 1;

  logic          CLK_50 = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [7:0]    secret;
  logic          busy;
  logic          found;
  logic [7:0]    guess_q;
  logic [CW-1:0] attempt_count;
  logic [7:0]    err_count;
  logic          frame_err;
  logic [7:0]    drv;

  cm_responder_if bus ();

  assign bus.cm_in = bus.cm_oe ? bus.cm_out : drv;

  cm_responder #(
    .HALF_PER  (H),
    .BASE_DLY  (BD),
    .LEAK_DLY  (LD),
    .REPLY_HOLD(RH),
    .CNT_W     (CW)
  ) dut (
    .CLK_50       (CLK_50),
    .rst_n        (rst_n),
    .enable       (enable),
    .secret       (secret),
    .bus          (bus),
    .busy         (busy),
    .found        (found),
    .guess_q      (guess_q),
    .attempt_count(attempt_count),
    .err_count    (err_count),
    .frame_err    (frame_err)
  );

  always #5 CLK_50 = ~CLK_50;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] m_secret;
  int         m_att;
  int         m_err;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no end of test, required end within 2ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Prefix length by comparing shifted values: largest l whose top l bits agree.
  function automatic int lead_len(input logic [7:0] g, input logic [7:0] s);
    for (int l = 8; l > 0; l--) begin
      if ((g >> (8 - l)) == (s >> (8 - l))) return l;
    end
    return 0;
  endfunction

  task automatic wait_cm_clk(input logic lvl, input string tag);
    int n = 0;
    while (bus.cm_clk !== lvl && n < 1000) begin
      @(negedge CLK_50);
      n++;
    end
    if (n >= 1000) check({tag, " timeout"}, 32'(n), 32'(0));
  endtask

  task automatic begin_session(input logic [7:0] s);
    int n = 0;
    secret = s;
    enable = 1'b1;
    @(negedge CLK_50);
    enable   = 1'b0;
    m_secret = s;
    m_att    = 0;
    m_err    = 0;
    check("begin value", {bus.cm_oe, bus.cm_out}, {1'b1, 8'h02});
    check("begin busy/found/att", {busy, found, 4'(attempt_count)}, {1'b1, 1'b0, 4'h0});
    while (bus.cm_oe === 1'b1 && n < 50) begin
      n++;
      @(negedge CLK_50);
    end
    check("begin hold", 32'(n), 32'(RH));
    check("begin release", {bus.cm_oe, bus.cm_out}, 9'h000);
  endtask

  task automatic do_frame(input logic [7:0] sb, input logic [7:0] db, input logic [7:0] eb,
                          output bit yes);
    int  n = 0;
    int  d;
    bit  ferr;
    bit  stray = 1'b0;
    wait_cm_clk(1'b1, "pace rise");
    check("oe in pulse", bus.cm_oe, 1'b0);
    while (bus.cm_clk === 1'b1 && n < 100) begin
      n++;
      @(negedge CLK_50);
    end
    check("pulse high width", 32'(n), 32'(H));
    wait_cm_clk(1'b1, "start rise");
    drv = sb;
    wait_cm_clk(1'b0, "start fall");
    wait_cm_clk(1'b1, "data rise");
    drv = db;
    wait_cm_clk(1'b0, "data fall");
    wait_cm_clk(1'b1, "end rise");
    drv = eb;
    wait_cm_clk(1'b0, "end fall");
    ferr = (sb != 8'h01) || (eb != 8'h05);
    d    = BD + LD * lead_len(db, m_secret);
    yes  = (db == m_secret) && !ferr;
    n = 0;
    while (bus.cm_oe !== 1'b1 && n < 300) begin
      if (bus.cm_clk !== 1'b0) stray = 1'b1;
      @(negedge CLK_50);
      n++;
    end
    check("reply latency", 32'(n), 32'(H + d));
    check("cm_clk low in delay", stray, 1'b0);
    m_att = (m_att < AttMax) ? m_att + 1 : AttMax;
    if (ferr) m_err = (m_err < 255) ? m_err + 1 : 255;
    check("reply value", bus.cm_out, yes ? 8'h03 : 8'h04);
    check("frame_err pulse", frame_err, ferr);
    check("attempt_count", 32'(attempt_count), 32'(m_att));
    check("err_count", err_count, 8'(m_err));
    check("guess_q", guess_q, db);
    n = 0;
    while (bus.cm_oe === 1'b1 && n < 50) begin
      if (n == 1) check("frame_err one cycle", frame_err, 1'b0);
      n++;
      @(negedge CLK_50);
    end
    check("reply hold", 32'(n), 32'(RH));
    if (yes) check("after yes found/busy", {found, busy}, 2'b10);
    else     check("after no found/busy", {found, busy}, 2'b01);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge CLK_50);
    check("reset bus", {bus.cm_clk, bus.cm_oe, bus.cm_out}, 10'h000);
    check("reset flags", {busy, found, frame_err}, 3'b000);
    check("reset counters", {4'(attempt_count), err_count, guess_q}, 20'h00000);
    rst_n = 1'b1;
    @(negedge CLK_50);
  endtask

  initial begin
    bit         yes;
    bit         bad_clk;
    bit         bad_oe;
    logic [7:0] s;
    logic [7:0] g;
    rst_n  = 1'b0;
    enable = 1'b0;
    secret = 8'h00;
    drv    = 8'h00;
    repeat (2) @(negedge CLK_50);
    do_reset();

    // 1: sequential guesser from 0x06
    begin_session(8'h09);
    for (int i = 0; i < 4; i++) begin
      do_frame(8'h01, 8'(6 + i), 8'h05, yes);
      check("t1 reply kind", yes, (i == 3));
    end

    // 2: leak timing for prefix lengths 1 and 7, then hit
    begin_session(8'hF0);
    do_frame(8'h01, 8'h80, 8'h05, yes);
    do_frame(8'h01, 8'hF1, 8'h05, yes);
    do_frame(8'h01, 8'hF0, 8'h05, yes);

    // 3: bad START slot, then a clean frame
    s = 8'($urandom_range(255, 6));
    begin_session(s);
    do_frame(8'h07, s, 8'h05, yes);
    do_frame(8'h01, s, 8'h05, yes);

    // 4: reset during the DATA high phase
    s = 8'($urandom_range(255, 6));
    begin_session(s);
    do_frame(8'h07, s ^ 8'h01, 8'h05, yes);
    wait_cm_clk(1'b1, "t4 pace");
    wait_cm_clk(1'b0, "t4 pace fall");
    wait_cm_clk(1'b1, "t4 start");
    drv = 8'h01;
    wait_cm_clk(1'b0, "t4 start fall");
    wait_cm_clk(1'b1, "t4 data");
    drv = 8'($urandom);
    repeat (2) @(negedge CLK_50);
    do_reset();

    // 5: attempt_count saturation
    begin_session(8'h20);
    for (int i = 0; i < 20; i++) begin
      do g = 8'($urandom); while (g == 8'h20);
      do_frame(8'h01, g, 8'h05, yes);
    end
    check("t5 err_count", err_count, 8'h00);
    do_reset();

    // 6: idle without enable, then enable mid-session is ignored
    bad_clk = 1'b0;
    bad_oe  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK_50);
      if (bus.cm_clk !== 1'b0) bad_clk = 1'b1;
      if (bus.cm_oe !== 1'b0) bad_oe = 1'b1;
    end
    check("t6 idle cm_clk", bad_clk, 1'b0);
    check("t6 idle cm_oe", bad_oe, 1'b0);
    s = 8'($urandom_range(255, 6));
    begin_session(s);
    do_frame(8'h01, ~s, 8'h05, yes);
    secret = ~s;
    enable = 1'b1;
    @(negedge CLK_50);
    enable = 1'b0;
    do_frame(8'h01, s, 8'h05, yes);
    check("t6 hit after ignored enable", yes, 1'b1);

    // Random session with occasional framing errors
    s = 8'($urandom_range(255, 6));
    begin_session(s);
    for (int i = 0; i < 6; i++) begin
      g = ($urandom_range(3, 0) == 0) ? s : 8'($urandom);
      do_frame(($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h01, g,
               ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h05, yes);
      if (yes) break;
    end
    if (!yes) do_frame(8'h01, s, 8'h05, yes);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
